// File: rtl/clk_sel_ctrl.sv
// Sequences PLL reset, lock wait, switch debounce and BUFGMUX select with post-switch holdoff.
// Latency: sw/pll_locked see 2 sync cycles; a held switch toggles clk_sel DEBOUNCE_CYCLES+4 cycles after the edge.
// No backpressure: free-running control block; sw changes during holdoff or lock loss simply wait.
// Optional CLK_SEL_LOCK_TIMEOUT_EN: re-resets the PLL if lock is not seen within LOCK_TIMEOUT cycles.
module clk_sel_ctrl #(
    parameter int CNT_W           = 24,
    parameter int PLL_RST_CYCLES  = 16,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLDOFF_CYCLES  = 64,
    parameter int LOCK_TIMEOUT    = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       clk_sel,
    output logic       ready,
    output logic       sw_event,
    output logic [7:0] switch_cnt,
    output logic [3:0] lock_retries
);

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        IDLE      = 3'd2,
        DEBOUNCE  = 3'd3,
        SWITCH    = 3'd4,
        HOLDOFF   = 3'd5
    } state_t;

    // Terminal counts: each phase ends on the cycle the counter equals the last index.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sw_meta;
    logic             sw_s;
    logic             lock_meta;
    logic             lock_s;

`ifdef CLK_SEL_LOCK_TIMEOUT_EN
    logic [3:0] retries_q;
    assign lock_retries = retries_q;
`else
    // Watchdog compiled out: retry count is constant and the timeout value has no user.
    logic timeout_unused;
    assign timeout_unused = ^TIMEOUT_LAST;
    assign lock_retries   = 4'd0;
`endif

    // Idle is the only state in which a user-visible switch request is accepted.
    assign ready = (state == IDLE);

    // Two-flop synchronisers for the asynchronous switch and lock inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta   <= 1'b0;
            sw_s      <= 1'b0;
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            sw_meta   <= sw;
            sw_s      <= sw_meta;
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    // Control sequencer with registered outputs; lock loss only parks the FSM, never moves clk_sel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RESET_PLL;
            cnt        <= '0;
            pll_rst    <= 1'b1;
            clk_sel    <= 1'b0;
            sw_event   <= 1'b0;
            switch_cnt <= 8'd0;
`ifdef CLK_SEL_LOCK_TIMEOUT_EN
            retries_q  <= 4'd0;
`endif
        end else begin
            sw_event <= 1'b0;
            case (state)
                RESET_PLL: begin
                    if (cnt == RST_LAST) begin
                        state   <= WAIT_LOCK;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        // Plain reload of the select, not a counted switch.
                        state   <= IDLE;
                        cnt     <= '0;
                        clk_sel <= sw_s;
                    end
`ifdef CLK_SEL_LOCK_TIMEOUT_EN
                    else if (cnt == TIMEOUT_LAST) begin
                        state   <= RESET_PLL;
                        cnt     <= '0;
                        pll_rst <= 1'b1;
                        if (retries_q != 4'd15) begin
                            retries_q <= retries_q + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                IDLE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (sw_s != clk_sel) begin
                        state <= DEBOUNCE;
                        cnt   <= '0;
                    end
                end
                DEBOUNCE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (sw_s == clk_sel) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state <= SWITCH;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SWITCH: begin
                    // Completes unconditionally so the mux never sees a half-made decision.
                    clk_sel    <= ~clk_sel;
                    sw_event   <= 1'b1;
                    switch_cnt <= switch_cnt + 8'd1;
                    state      <= HOLDOFF;
                    cnt        <= '0;
                end
                HOLDOFF: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= RESET_PLL;
                    cnt     <= '0;
                    pll_rst <= 1'b1;
                end
            endcase
        end
    end

endmodule
